lfsr_noise_gen: RTL and testbench

LFSR_NOISE_GEN -- requirements
Module: lfsr_noise_gen

---
 rtl/lfsr_noise_pkg.sv | 14 +
 rtl/lfsr_noise_ch.sv | 68 ++++++
 rtl/lfsr_noise_gen.sv | 82 ++++++++
 tb/tb_lfsr_noise_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_noise_pkg.sv
// Shared mode encoding and default LFSR constants for the noise generator.
package lfsr_noise_pkg;

    typedef enum logic [1:0] {
        MODE_UNIFORM    = 2'd0,
        MODE_TRIANGULAR = 2'd1,
        MODE_OFF_A      = 2'd2,
        MODE_OFF_B      = 2'd3
    } noise_mode_e;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr_noise_ch.sv
// One noise channel: Fibonacci LFSR, previous-sample memory, shaping and gain scaling.
module lfsr_noise_ch
    import lfsr_noise_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
    parameter int                OUT_W  = 16,
    parameter int                GAIN_W = 4,
    parameter int                CH_IDX = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    input  logic                    load,
    input  logic [LFSR_W-1:0]       load_val,
    input  noise_mode_e             mode,
    input  logic [GAIN_W-1:0]       gain,
    output logic signed [OUT_W-1:0] scaled
);

    localparam int ROT    = CH_IDX % LFSR_W;
    localparam int PROD_W = OUT_W + GAIN_W + 1;

    logic [LFSR_W-1:0]       state;
    logic signed [OUT_W-1:0] prev;
    logic signed [OUT_W-1:0] raw;
    logic signed [OUT_W-1:0] shaped;
    logic signed [PROD_W-1:0] product;

    // Each channel starts from the seed rotated by its index so channels decorrelate.
    function automatic logic [LFSR_W-1:0] rotl(input logic [LFSR_W-1:0] x);
        logic [2*LFSR_W-1:0] dbl;
        dbl = {x, x};
        return dbl[2*LFSR_W-1-ROT -: LFSR_W];
    endfunction

    assign raw = state[LFSR_W-1 -: OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= rotl(SEED);
            prev  <= '0;
        end else if (load) begin
            state <= rotl(load_val);
            prev  <= '0;
        end else if (step) begin
            prev  <= raw;
            state <= {state[LFSR_W-2:0], ^(state & TAPS)};
        end
    end

    // Halving both terms before summing keeps the triangular sum inside OUT_W.
    always_comb begin
        shaped = '0;
        case (mode)
            MODE_UNIFORM:    shaped = raw;
            MODE_TRIANGULAR: shaped = (raw >>> 1) + (prev >>> 1);
            default:         shaped = '0;
        endcase
    end

    always_comb begin
        product = PROD_W'(shaped) * $signed(PROD_W'({1'b0, gain}));
        scaled  = OUT_W'(product >>> GAIN_W);
    end

endmodule

// File: rtl/lfsr_noise_gen.sv
// Multi-channel LFSR noise source with gain control and a two-cycle valid pipeline.
module lfsr_noise_gen
    import lfsr_noise_pkg::*;
#(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS     = DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED,
    parameter int                OUT_W    = 16,
    parameter int                GAIN_W   = 4,
    parameter int                GAIN_RST = 1,
    parameter int                NUM_CH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic                    gain_inc,
    input  logic                    gain_dec,
    input  logic [1:0]              mode,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed_val,
    output logic [NUM_CH*OUT_W-1:0] noise_out,
    output logic                    noise_valid,
    output logic [GAIN_W-1:0]       gain
);

    logic                    step;
    logic                    tick_d;
    logic [LFSR_W-1:0]       seed_eff;
    logic signed [OUT_W-1:0] scaled [NUM_CH];

    // A zero reseed would lock the LFSR, so fall back to the default seed.
    assign seed_eff = (seed_val == '0) ? SEED : seed_val;
    assign step     = sample_tick & ~seed_load;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        lfsr_noise_ch #(
            .LFSR_W (LFSR_W),
            .TAPS   (TAPS),
            .SEED   (SEED),
            .OUT_W  (OUT_W),
            .GAIN_W (GAIN_W),
            .CH_IDX (c)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .step     (step),
            .load     (seed_load),
            .load_val (seed_eff),
            .mode     (noise_mode_e'(mode)),
            .gain     (gain),
            .scaled   (scaled[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gain <= GAIN_W'(GAIN_RST);
        end else if (gain_inc && !gain_dec && gain != '1) begin
            gain <= gain + 1'b1;
        end else if (gain_dec && !gain_inc && gain != '0) begin
            gain <= gain - 1'b1;
        end
    end

    // A reseed landing between the step and the capture cancels that sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_d      <= 1'b0;
            noise_valid <= 1'b0;
            noise_out   <= '0;
        end else begin
            tick_d      <= step;
            noise_valid <= tick_d & ~seed_load;
            if (tick_d && !seed_load) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    noise_out[c*OUT_W +: OUT_W] <= scaled[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Randomised and directed checks of lfsr_noise_gen against an integer reference model.
module tb_lfsr_noise_gen;

    logic        clk;
    logic        rst;
    logic        sample_tick;
    logic        gain_inc;
    logic        gain_dec;
    logic [1:0]  mode;
    logic        seed_load;
    logic [15:0] seed_val;
    logic [31:0] noise_out;
    logic        noise_valid;
    logic [3:0]  gain;

    int numChecks = 0;
    int numFails  = 0;

    int          mSt   [2];
    int          mPrev [2];
    logic [15:0] mOut  [2];
    int          mGain;
    bit          mValid;
    bit          mPend;

    lfsr_noise_gen dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .gain_inc    (gain_inc),
        .gain_dec    (gain_dec),
        .mode        (mode),
        .seed_load   (seed_load),
        .seed_val    (seed_val),
        .noise_out   (noise_out),
        .noise_valid (noise_valid),
        .gain        (gain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Rotation as arithmetic: multiply by 2^n and fold the overflow back in.
    function automatic int rotSeed(input int s, input int n);
        int v;
        v = s;
        for (int i = 0; i < n; i++) v = ((v * 2) % 65536) + (v / 32768);
        return v;
    endfunction

    function automatic int nextState(input int s);
        return ((s * 2) % 65536) + ($countones(s[15:0] & 16'hB400) % 2);
    endfunction

    function automatic int asSigned(input int s);
        return (s >= 32768) ? s - 65536 : s;
    endfunction

    function automatic logic [15:0] expectedOut(input int m, input int st, input int pv, input int g);
        int smp;
        if (m == 0)      smp = asSigned(st);
        else if (m == 1) smp = (asSigned(st) >>> 1) + (pv >>> 1);
        else             smp = 0;
        return 16'((smp * g) >>> 4);
    endfunction

    task automatic modelEdge(input bit r, tk, inc, dec, input logic [1:0] m, input bit sl,
                             input logic [15:0] sv);
        int sd;
        if (r) begin
            for (int c = 0; c < 2; c++) begin
                mSt[c] = rotSeed(16'hACE1, c); mPrev[c] = 0; mOut[c] = '0;
            end
            mGain = 1; mValid = 0; mPend = 0;
            return;
        end
        mValid = mPend && !sl;
        if (mValid)
            for (int c = 0; c < 2; c++) mOut[c] = expectedOut(int'(m), mSt[c], mPrev[c], mGain);
        if (inc && !dec) mGain = (mGain < 15) ? mGain + 1 : 15;
        if (dec && !inc) mGain = (mGain > 0) ? mGain - 1 : 0;
        if (sl) begin
            sd = (sv == 16'h0) ? 16'hACE1 : int'(sv);
            for (int c = 0; c < 2; c++) begin mSt[c] = rotSeed(sd, c); mPrev[c] = 0; end
            mPend = 0;
        end else if (tk) begin
            for (int c = 0; c < 2; c++) begin
                mPrev[c] = asSigned(mSt[c]); mSt[c] = nextState(mSt[c]);
            end
            mPend = 1;
        end else begin
            mPend = 0;
        end
    endtask

    // Drive one cycle (called at a falling edge), update the model, compare at the next falling edge.
    task automatic applyStimulus(input bit r, tk, inc, dec, input logic [1:0] m, input bit sl,
                                 input logic [15:0] sv);
        rst = r; sample_tick = tk; gain_inc = inc; gain_dec = dec;
        mode = m; seed_load = sl; seed_val = sv;
        @(posedge clk);
        modelEdge(r, tk, inc, dec, m, sl, sv);
        @(negedge clk);
        checkOutput("valid",  32'(noise_valid), 32'(mValid));
        checkOutput("gain",   32'(gain), 32'(mGain));
        checkOutput("out0",   32'(noise_out[15:0]), 32'(mOut[0]));
        checkOutput("out1",   32'(noise_out[31:16]), 32'(mOut[1]));
        checkOutput("state0", 32'(dut.g_ch[0].u_ch.state), 32'(mSt[0]));
        checkOutput("state1", 32'(dut.g_ch[1].u_ch.state), 32'(mSt[1]));
    endtask

    initial begin
        bit zeroSeen;
        bit chDiffer;
        rst = 1; sample_tick = 0; gain_inc = 0; gain_dec = 0;
        mode = 0; seed_load = 0; seed_val = 0;
        @(negedge clk);

        // Reset state.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_gain", 32'(gain), 32'd1);
        checkOutput("rst_state0", 32'(dut.g_ch[0].u_ch.state), 32'hACE1);
        checkOutput("rst_out", noise_out, 32'd0);

        // First tick in uniform mode.
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("tick_state0", 32'(dut.g_ch[0].u_ch.state), 32'h59C3);
        checkOutput("tick_novalid_yet", 32'(noise_valid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("tick_out0", 32'(noise_out[15:0]), 32'd1436);
        checkOutput("tick_valid", 32'(noise_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("tick_valid_drop", 32'(noise_valid), 32'd0);
        checkOutput("tick_out_hold", 32'(noise_out[15:0]), 32'd1436);

        // Gain saturation both ways and simultaneous requests.
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("gain_max", 32'(gain), 32'd15);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("gain_both_hold", 32'(gain), 32'd15);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("gain_min", 32'(gain), 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("gain0_out", noise_out, 32'd0);
        checkOutput("gain0_valid", 32'(noise_valid), 32'd1);

        // Zero reseed with a competing tick.
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 16'h0000);
        checkOutput("reseed_state0", 32'(dut.g_ch[0].u_ch.state), 32'hACE1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("reseed_novalid", 32'(noise_valid), 32'd0);

        // Off mode keeps ticking, then back to triangular.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 2, 0, 0);
            if (i > 0) begin
                checkOutput("off_out", noise_out, 32'd0);
                checkOutput("off_valid", 32'(noise_valid), 32'd1);
            end
        end
        applyStimulus(0, 1, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("tri_valid", 32'(noise_valid), 32'd1);

        // Reset right after a tick discards the pending sample.
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("rstmid_valid", 32'(noise_valid), 32'd0);
        checkOutput("rstmid_out", noise_out, 32'd0);
        checkOutput("rstmid_gain", 32'(gain), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstmid_valid_after", 32'(noise_valid), 32'd0);

        // Full period from the default seed.
        zeroSeen = 0;
        chDiffer = 0;
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 0);
            if (dut.g_ch[0].u_ch.state == 16'h0) zeroSeen = 1;
            if (noise_valid && noise_out[15:0] != noise_out[31:16]) chDiffer = 1;
        end
        checkOutput("period_return", 32'(dut.g_ch[0].u_ch.state), 32'hACE1);
        checkOutput("period_nozero", 32'(zeroSeen), 32'd0);
        checkOutput("ch1_differs", 32'(chDiffer), 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit          r, tk, inc, dec, sl;
            logic [1:0]  m;
            logic [15:0] sv;
            r   = ($urandom_range(0, 63) == 0);
            tk  = $urandom_range(0, 1);
            inc = ($urandom_range(0, 3) == 0);
            dec = ($urandom_range(0, 3) == 0);
            sl  = ($urandom_range(0, 15) == 0);
            m   = 2'($urandom_range(0, 3));
            sv  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            applyStimulus(r, tk, inc, dec, m, sl, sv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule
